// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS core's memory-side blocks.
// Holds the responder state encoding and the bus width constants.
package mips_mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      RESP = 2'b10
   } state_t;

   localparam int WORD_W     = 32;
   localparam int BYTE_OFS_W = 2;

endpackage

// File: rtl/dmem_array.sv
// Word-wide data RAM: synchronous write, combinational read.
// Contents are deliberately not reset.
module dmem_array
   import mips_mem_pkg::*;
#(
   parameter int DEPTH = 64,
   parameter int IDX_W = 6
) (
   input  logic              clk,
   input  logic              we,
   input  logic [IDX_W-1:0]  idx,
   input  logic [WORD_W-1:0] wd,
   output logic [WORD_W-1:0] rd
);

   logic [WORD_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[idx] <= wd;
   end

   assign rd = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder with req/ack handshake, programmable wait states
// and alignment/range checking in front of a word RAM.
module dmem_responder
   import mips_mem_pkg::*;
#(
   parameter int DEPTH       = 64,
   parameter int WAIT_STATES = 2
) (
   input  logic              i_clk_w,
   input  logic              i_rst_w,
   input  logic              i_req_w,
   input  logic              i_we_w,
   input  logic [WORD_W-1:0] i_addr_w,
   input  logic [WORD_W-1:0] i_wd_w,
   output logic              o_ack_w,
   output logic              o_err_w,
   output logic [WORD_W-1:0] o_rd_w,
   output logic              o_busy_w
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic              cap_we;
   logic [WORD_W-1:0] cap_addr;
   logic [WORD_W-1:0] cap_wd;

   logic              addr_err;
   logic              commit;
   logic              ram_we;
   logic [IDX_W-1:0]  ram_idx;
   logic [WORD_W-1:0] ram_rd;

   // Upper address bits are part of the range check, so high addresses never alias.
   assign addr_err = (cap_addr[BYTE_OFS_W-1:0] != '0) ||
                     ({{BYTE_OFS_W{1'b0}}, cap_addr[WORD_W-1:BYTE_OFS_W]} >= WORD_W'(DEPTH));
   assign commit   = (state == BUSY) && (cnt == '0);
   assign ram_we   = commit && cap_we && !addr_err;
   assign ram_idx  = cap_addr[IDX_W+BYTE_OFS_W-1:BYTE_OFS_W];

   dmem_array #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_array (
      .clk (i_clk_w),
      .we  (ram_we),
      .idx (ram_idx),
      .wd  (cap_wd),
      .rd  (ram_rd)
   );

   always_ff @(posedge i_clk_w or negedge i_rst_w) begin
      if (!i_rst_w) begin
         state    <= IDLE;
         cnt      <= '0;
         cap_we   <= 1'b0;
         cap_addr <= '0;
         cap_wd   <= '0;
         o_ack_w  <= 1'b0;
         o_err_w  <= 1'b0;
         o_rd_w   <= '0;
         o_busy_w <= 1'b0;
      end else begin
         o_ack_w <= 1'b0;
         o_err_w <= 1'b0;
         case (state)
            IDLE: begin
               if (i_req_w) begin
                  cap_we   <= i_we_w;
                  cap_addr <= i_addr_w;
                  cap_wd   <= i_wd_w;
                  cnt      <= CNT_W'(WAIT_STATES);
                  state    <= BUSY;
                  o_busy_w <= 1'b1;
               end
            end
            BUSY: begin
               if (cnt != '0) begin
                  cnt <= cnt - CNT_W'(1);
               end else begin
                  state   <= RESP;
                  o_ack_w <= 1'b1;
                  o_err_w <= addr_err;
                  if (!addr_err && !cap_we) o_rd_w <= ram_rd;
               end
            end
            RESP: begin
               state    <= IDLE;
               o_busy_w <= 1'b0;
            end
            default: begin
               state    <= IDLE;
               o_busy_w <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed table, reset/back-to-back
// sequences and randomized accesses against a word-array reference model.
module tb_dmem_responder;

   localparam int DEPTH = 64;
   localparam int WS    = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic        req = 1'b0, we = 1'b0;
   logic [31:0] addr = '0, wd = '0;
   logic        ack, err, busy;
   logic [31:0] rd;

   logic        req0 = 1'b0, we0 = 1'b0;
   logic [31:0] addr0 = '0, wd0 = '0;
   logic        ack0, err0, busy0;
   logic [31:0] rd0;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
      .i_clk_w (clk),  .i_rst_w (rst_n), .i_req_w (req), .i_we_w (we),
      .i_addr_w(addr), .i_wd_w  (wd),    .o_ack_w (ack), .o_err_w(err),
      .o_rd_w  (rd),   .o_busy_w(busy)
   );

   dmem_responder #(.DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
      .i_clk_w (clk),   .i_rst_w (rst_n), .i_req_w (req0), .i_we_w (we0),
      .i_addr_w(addr0), .i_wd_w  (wd0),   .o_ack_w (ack0), .o_err_w(err0),
      .o_rd_w  (rd0),   .o_busy_w(busy0)
   );

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wd;
      logic        exp_err;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t        vecs[6];
   logic [31:0] model_mem[DEPTH];
   logic [31:0] rd_exp;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // One full handshake on the WAIT_STATES=2 instance; inputs are scrambled while busy.
   task automatic applyStimulus(input logic s_we, input logic [31:0] s_addr, input logic [31:0] s_wd,
                                output int lat, output logic s_err, output logic [31:0] s_rd);
      @(negedge clk);
      req = 1'b1; we = s_we; addr = s_addr; wd = s_wd;
      @(posedge clk);
      @(negedge clk);
      req = 1'b0; we = ~s_we; addr = $urandom; wd = $urandom;
      checkOutput("busy_after_req", {31'b0, busy}, 32'd1);
      lat = -1; s_err = 1'b0; s_rd = '0;
      for (int k = 0; k < 40; k++) begin
         if (ack) begin
            lat = k; s_err = err; s_rd = rd;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic runAccess(input string name, input logic s_we, input logic [31:0] s_addr,
                            input logic [31:0] s_wd, input logic e_err, input logic [31:0] e_rd);
      int          lat;
      logic        a_err;
      logic [31:0] a_rd;
      applyStimulus(s_we, s_addr, s_wd, lat, a_err, a_rd);
      checkOutput({name, "_latency"}, 32'(lat), 32'(WS + 1));
      checkOutput({name, "_err"}, {31'b0, a_err}, {31'b0, e_err});
      checkOutput({name, "_rd"}, a_rd, e_rd);
   endtask

   initial begin
      logic        r_we, r_err;
      logic [31:0] r_addr, r_wd;
      int          a1, a2, low_cnt, n_ack, err_seen;

      vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
      vecs[1] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};
      vecs[2] = '{1'b1, 32'h0000_0012, 32'hCAFE_F00D, 1'b1, 32'hDEAD_BEEF};
      vecs[3] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};
      vecs[4] = '{1'b0, 32'h0000_0100, 32'h0000_0000, 1'b1, 32'hDEAD_BEEF};
      vecs[5] = '{1'b1, 32'h0000_0020, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};

      // Reset held for three cycles, then idle.
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      checkOutput("idle_ack",  {31'b0, ack},  32'd0);
      checkOutput("idle_err",  {31'b0, err},  32'd0);
      checkOutput("idle_busy", {31'b0, busy}, 32'd0);
      checkOutput("idle_rd",   rd,            32'd0);
      checkOutput("idle_busy0", {31'b0, busy0}, 32'd0);

      for (int i = 0; i < 6; i++)
         runAccess($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wd,
                   vecs[i].exp_err, vecs[i].exp_rd);

      // Reset in the middle of BUSY must drop the pending store and never ack.
      @(negedge clk);
      req = 1'b1; we = 1'b1; addr = 32'h0000_0020; wd = 32'h1234_5678;
      @(posedge clk);
      @(negedge clk);
      req = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1 checkOutput("midreset_busy", {31'b0, busy}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      n_ack = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (ack) n_ack++;
      end
      checkOutput("midreset_no_ack", 32'(n_ack), 32'd0);
      runAccess("midreset_load", 1'b0, 32'h0000_0020, 32'h0, 1'b0, 32'h0000_0000);
      rd_exp = 32'h0;

      // Fill every word so the random phase always has a known model.
      for (int i = 0; i < DEPTH; i++) begin
         model_mem[i] = $urandom;
         runAccess("fill", 1'b1, 32'(i * 4), model_mem[i], 1'b0, rd_exp);
      end

      for (int n = 0; n < 40; n++) begin
         r_we   = 1'($urandom_range(0, 1));
         r_addr = 32'($urandom_range(0, DEPTH + 3)) * 4;
         if ($urandom_range(0, 3) == 0) r_addr = r_addr + 32'($urandom_range(1, 3));
         if ($urandom_range(0, 15) == 0) r_addr = r_addr | 32'h4000_0000;
         r_wd   = $urandom;
         r_err  = (r_addr % 4 != 0) || (r_addr / 4 >= DEPTH);
         if (!r_err) begin
            if (r_we) model_mem[r_addr / 4] = r_wd;
            else      rd_exp = model_mem[r_addr / 4];
         end
         runAccess($sformatf("rand%0d", n), r_we, r_addr, r_wd, r_err, rd_exp);
      end

      // WAIT_STATES=0 with request held high through the ack.
      @(negedge clk);
      req0 = 1'b1; we0 = 1'b1; addr0 = 32'h0000_0004; wd0 = $urandom;
      a1 = -1; a2 = -1; low_cnt = 0; n_ack = 0; err_seen = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (ack0) begin
            n_ack++;
            if (err0) err_seen++;
            if (a1 < 0) a1 = k;
            else if (a2 < 0) begin
               a2 = k;
               req0 = 1'b0;
            end
         end
         if (a1 >= 0 && a2 < 0 && !ack0 && !busy0) low_cnt++;
      end
      checkOutput("b2b_first_ack", 32'(a1), 32'd1);
      checkOutput("b2b_ack_gap",   32'(a2 - a1), 32'd3);
      checkOutput("b2b_idle_gap",  32'(low_cnt), 32'd1);
      checkOutput("b2b_ack_count", 32'(n_ack), 32'd2);
      checkOutput("b2b_err",       32'(err_seen), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
